// File: rtl/hazard_tracker_if.sv
// -----------------------------------------------------------------------------
// hazard_tracker_if
//
// Bundle of the decode-stage signals consumed by the hazard tracker and the
// stall / flush / forwarding controls it returns to the pipeline.
//
//   ID side (into the tracker)
//     id_valid      ID holds a real instruction
//     id_opcode     ID opcode, 7 bits
//     id_rd/rs1/rs2 ID register fields, 5 bits each
//     ex_redirect   taken branch / jump resolved in EX this cycle
//     dmem_ready    data memory completes the MEM access this cycle
//
//   Control side (out of the tracker)
//     ex_addr/mem_addr/wb_addr  destination of the EX/MEM/WB instruction, 0 if none
//     pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
//     ex_mem_stall, mem_wb_bubble  pipeline register controls
//     dmem_wait     tracker is waiting on data memory
//     stall_cnt     saturating count of PC-stall cycles
//
// master: the pipeline side that drives ID information.
// slave : the hazard tracker itself.
// -----------------------------------------------------------------------------
interface hazard_tracker_if;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        ex_redirect;
  logic        dmem_ready;

  logic [4:0]  ex_addr;
  logic [4:0]  mem_addr;
  logic [4:0]  wb_addr;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_bubble;
  logic        ex_mem_stall;
  logic        mem_wb_bubble;
  logic        dmem_wait;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_opcode, id_rd, id_rs1, id_rs2, ex_redirect, dmem_ready,
    input  ex_addr, mem_addr, wb_addr, pc_stall, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_bubble, ex_mem_stall, mem_wb_bubble, dmem_wait,
           stall_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, ex_redirect, dmem_ready,
    output ex_addr, mem_addr, wb_addr, pc_stall, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_bubble, ex_mem_stall, mem_wb_bubble, dmem_wait,
           stall_cnt
  );
endinterface

// File: rtl/hazard_tracker.sv
// -----------------------------------------------------------------------------
// hazard_tracker
//
// Decode-stage hazard and in-flight destination tracker for a 5-stage RISC-V
// pipeline. Every instruction leaving ID is recorded in a three-deep slot
// chain (EX, MEM, WB) whose destination fields feed the forwarding logic.
// The block also produces all pipeline stalls, flushes and bubbles:
//   - data-memory wait freeze (highest priority)
//   - control-transfer redirect flush
//   - load-use interlock (one bubble)
// and keeps a saturating count of PC-stall cycles.
//
// Ports
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    hazard_tracker_if.slave (ID inputs, stage addresses, controls)
// -----------------------------------------------------------------------------
module hazard_tracker (
  input  logic            clk,
  input  logic            rst_n,
  hazard_tracker_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Opcode constants
  // ---------------------------------------------------------------------------
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // One in-flight instruction. rd is stored already qualified by wr, so a
  // slot that does not write a register always carries rd = 0 and the stage
  // address outputs can be taken straight from the flops.
  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [4:0] rd;
    logic       is_load;
    logic       is_mem;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid:   1'b0,
                                   wr:      1'b0,
                                   rd:      5'd0,
                                   is_load: 1'b0,
                                   is_mem:  1'b0};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Opcode class helpers
  // ---------------------------------------------------------------------------
  function automatic logic opc_uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_STORE,
      OPC_OPIMM, OPC_OP, OPC_BRANCH: opc_uses_rs1 = 1'b1;
      default:                       opc_uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic opc_uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_STORE, OPC_OP, OPC_BRANCH: opc_uses_rs2 = 1'b1;
      default:                       opc_uses_rs2 = 1'b0;
    endcase
  endfunction

  // Recognised opcodes that produce a register result. rd = x0 is filtered
  // separately by the caller.
  function automatic logic opc_writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_JALR, OPC_JAL, OPC_OPIMM,
      OPC_OP, OPC_LUI, OPC_AUIPC: opc_writes_rd = 1'b1;
      default:                    opc_writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic opc_is_mem(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE: opc_is_mem = 1'b1;
      default:             opc_is_mem = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  slot_t       ex_q,  ex_d;
  slot_t       mem_q, mem_d;
  slot_t       wb_q,  wb_d;
  state_t      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  slot_t       id_slot;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        lu;
  logic        mem_hold;

  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_bubble;
  logic        ex_mem_stall;
  logic        mem_wb_bubble;

  // Decode the ID instruction into the slot format it will occupy in EX.
  always_comb begin
    id_slot = SLOT_EMPTY;
    if (bus.id_valid) begin
      id_slot.valid   = 1'b1;
      id_slot.wr      = opc_writes_rd(bus.id_opcode) && (bus.id_rd != 5'd0);
      id_slot.rd      = id_slot.wr ? bus.id_rd : 5'd0;
      id_slot.is_load = (bus.id_opcode == OPC_LOAD);
      id_slot.is_mem  = opc_is_mem(bus.id_opcode);
    end else begin
      id_slot = SLOT_EMPTY;
    end
  end

  // Hazard detection: load-use against the EX slot, and the memory freeze.
  always_comb begin
    rs1_hit  = opc_uses_rs1(bus.id_opcode) && (ex_q.rd == bus.id_rs1);
    rs2_hit  = opc_uses_rs2(bus.id_opcode) && (ex_q.rd == bus.id_rs2);
    lu       = ex_q.valid && ex_q.is_load && ex_q.wr && bus.id_valid &&
               (rs1_hit || rs2_hit);
    mem_hold = mem_q.valid && mem_q.is_mem && !bus.dmem_ready;
  end

  // Prioritised pipeline action and the matching next slot contents.
  // A memory freeze beats a redirect (EX is frozen and re-presents the
  // redirect later); a redirect beats load-use because ID is squashed anyway.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    ex_d          = id_slot;
    mem_d         = ex_q;
    wb_d          = mem_q;
    if (mem_hold) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
      ex_d          = ex_q;
      mem_d         = mem_q;
      wb_d          = SLOT_EMPTY;
    end else if (bus.ex_redirect) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_d          = SLOT_EMPTY;
    end else if (lu) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_d          = SLOT_EMPTY;
    end else begin
      ex_d          = id_slot;
    end
  end

  // Memory wait state: entered on a freeze, left once memory answers.
  always_comb begin
    case (state_q)
      ST_RUN:  state_d = mem_hold ? ST_WAIT : ST_RUN;
      ST_WAIT: state_d = bus.dmem_ready ? ST_RUN : ST_WAIT;
      default: state_d = ST_RUN;
    endcase
  end

  // Saturating stall-cycle counter.
  always_comb begin
    if (pc_stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Slot chain, FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= SLOT_EMPTY;
      mem_q       <= SLOT_EMPTY;
      wb_q        <= SLOT_EMPTY;
      state_q     <= ST_RUN;
      stall_cnt_q <= 16'd0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Output drive: addresses and status straight from flops, controls combinational.
  always_comb begin
    bus.ex_addr       = ex_q.rd;
    bus.mem_addr      = mem_q.rd;
    bus.wb_addr       = wb_q.rd;
    bus.dmem_wait     = (state_q == ST_WAIT);
    bus.stall_cnt     = stall_cnt_q;
    bus.pc_stall      = pc_stall;
    bus.if_id_stall   = if_id_stall;
    bus.if_id_flush   = if_id_flush;
    bus.id_ex_stall   = id_ex_stall;
    bus.id_ex_bubble  = id_ex_bubble;
    bus.ex_mem_stall  = ex_mem_stall;
    bus.mem_wb_bubble = mem_wb_bubble;
  end

  // WB only feeds its address out; its remaining attributes are kept so the
  // three slots share one format, and are folded here so they read as used.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb_q.valid, wb_q.wr, wb_q.is_load, wb_q.is_mem,
                              mem_q.wr, mem_q.is_load, ex_q.is_mem};

endmodule

// File: tb/tb_hazard_tracker.sv
// -----------------------------------------------------------------------------
// tb_hazard_tracker
//
// Self-checking bench for hazard_tracker. A reference model keeps the raw
// instructions (valid, opcode, rd) occupying EX/MEM/WB and derives every
// expected output from the opcode-class rules each cycle. Directed sequences
// cover the listed corner cases, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_hazard_tracker;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JUNK   = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hazard_tracker_if bus_if ();

  hazard_tracker u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: raw instructions in EX (0), MEM (1), WB (2)
  // ---------------------------------------------------------------------------
  typedef struct {
    bit       v;
    bit [6:0] op;
    bit [4:0] rd;
  } ins_t;

  ins_t pipe [3];
  bit   m_wait;
  int   m_cnt;

  function automatic bit known(input bit [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL,
                      OP_OPIMM, OP_OP, OP_LUI, OP_AUIPC};
  endfunction

  function automatic bit writes(input ins_t i);
    return i.v && known(i.op) && !(i.op inside {OP_STORE, OP_BRANCH}) &&
           (i.rd != 5'd0);
  endfunction

  function automatic bit [4:0] dest(input ins_t i);
    return writes(i) ? i.rd : 5'd0;
  endfunction

  function automatic bit reads1(input bit [6:0] op);
    return op inside {OP_JALR, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_BRANCH};
  endfunction

  function automatic bit reads2(input bit [6:0] op);
    return op inside {OP_STORE, OP_OP, OP_BRANCH};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      pipe[i].v  = 1'b0;
      pipe[i].op = 7'd0;
      pipe[i].rd = 5'd0;
    end
    m_wait = 1'b0;
    m_cnt  = 0;
  endtask

  // One pipeline cycle: drive ID at the falling edge, check, advance the model.
  task automatic step(input bit v, input bit [6:0] op, input bit [4:0] rd,
                      input bit [4:0] rs1, input bit [4:0] rs2,
                      input bit redir, input bit ready);
    ins_t idi;
    bit   hold, lu, freeze_ok, redir_ok, lu_ok;
    @(negedge clk);
    bus_if.id_valid    = v;
    bus_if.id_opcode   = op;
    bus_if.id_rd       = rd;
    bus_if.id_rs1      = rs1;
    bus_if.id_rs2      = rs2;
    bus_if.ex_redirect = redir;
    bus_if.dmem_ready  = ready;
    #1;
    check_eq("ex_addr",   bus_if.ex_addr,   dest(pipe[0]));
    check_eq("mem_addr",  bus_if.mem_addr,  dest(pipe[1]));
    check_eq("wb_addr",   bus_if.wb_addr,   dest(pipe[2]));
    check_eq("dmem_wait", bus_if.dmem_wait, m_wait);
    check_eq("stall_cnt", bus_if.stall_cnt, m_cnt);

    hold = pipe[1].v && (pipe[1].op inside {OP_LOAD, OP_STORE}) && !ready;
    lu   = pipe[0].v && (pipe[0].op == OP_LOAD) && writes(pipe[0]) && v &&
           ((reads1(op) && pipe[0].rd == rs1) || (reads2(op) && pipe[0].rd == rs2));
    freeze_ok = hold;
    redir_ok  = !hold && redir;
    lu_ok     = !hold && !redir && lu;

    check_eq("pc_stall",      bus_if.pc_stall,      freeze_ok || lu_ok);
    check_eq("if_id_stall",   bus_if.if_id_stall,   freeze_ok || lu_ok);
    check_eq("if_id_flush",   bus_if.if_id_flush,   redir_ok);
    check_eq("id_ex_stall",   bus_if.id_ex_stall,   freeze_ok);
    check_eq("id_ex_bubble",  bus_if.id_ex_bubble,  redir_ok || lu_ok);
    check_eq("ex_mem_stall",  bus_if.ex_mem_stall,  freeze_ok);
    check_eq("mem_wb_bubble", bus_if.mem_wb_bubble, freeze_ok);

    if (freeze_ok || lu_ok) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    m_wait = m_wait ? !ready : hold;

    idi.v  = v;
    idi.op = op;
    idi.rd = rd;
    if (hold) begin
      pipe[2].v = 1'b0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (redir || lu) pipe[0].v = 1'b0;
      else             pipe[0]   = idi;
    end
  endtask

  task automatic idle(input bit redir, input bit ready);
    step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, redir, ready);
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    bus_if.id_valid    = 1'b0;
    bus_if.id_opcode   = 7'd0;
    bus_if.id_rd       = 5'd0;
    bus_if.id_rs1      = 5'd0;
    bus_if.id_rs2      = 5'd0;
    bus_if.ex_redirect = 1'b0;
    bus_if.dmem_ready  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_ex_addr",   bus_if.ex_addr,   32'd0);
    check_eq("rst_mem_addr",  bus_if.mem_addr,  32'd0);
    check_eq("rst_wb_addr",   bus_if.wb_addr,   32'd0);
    check_eq("rst_stall_cnt", bus_if.stall_cnt, 32'd0);
    check_eq("rst_dmem_wait", bus_if.dmem_wait, 32'd0);
    check_eq("rst_pc_stall",  bus_if.pc_stall,  32'd0);
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus_if.id_valid    = 1'b0;
    bus_if.id_opcode   = 7'd0;
    bus_if.id_rd       = 5'd0;
    bus_if.id_rs1      = 5'd0;
    bus_if.id_rs2      = 5'd0;
    bus_if.ex_redirect = 1'b0;
    bus_if.dmem_ready  = 1'b1;
    model_clear();
    do_reset();

    // Normal OP x5 shows on ex_addr one cycle after it sits in ID.
    step(1'b1, OP_OP, 5'd5, 5'd1, 5'd2, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    check_eq("op_ex_addr", bus_if.ex_addr, 32'd5);

    // lw x5 ; add x6,x5,x7 -> one bubble.
    do_reset();
    step(1'b1, OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0, 1'b1);
    step(1'b1, OP_OP, 5'd6, 5'd5, 5'd7, 1'b0, 1'b1);
    check_eq("lu_pc_stall",     bus_if.pc_stall,     32'd1);
    check_eq("lu_if_id_stall",  bus_if.if_id_stall,  32'd1);
    check_eq("lu_id_ex_bubble", bus_if.id_ex_bubble, 32'd1);
    step(1'b1, OP_OP, 5'd6, 5'd5, 5'd7, 1'b0, 1'b1);
    check_eq("lu_after_ex",  bus_if.ex_addr,   32'd0);
    check_eq("lu_after_mem", bus_if.mem_addr,  32'd5);
    check_eq("lu_after_cnt", bus_if.stall_cnt, 32'd1);
    check_eq("lu_no_refire", bus_if.pc_stall,  32'd0);

    // lw x5 ; sw x8,0(x5) stalls. lw x5 ; lui x5 does not.
    do_reset();
    step(1'b1, OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0, 1'b1);
    step(1'b1, OP_STORE, 5'd0, 5'd5, 5'd8, 1'b0, 1'b1);
    check_eq("sw_stall", bus_if.pc_stall, 32'd1);
    do_reset();
    step(1'b1, OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0, 1'b1);
    step(1'b1, OP_LUI, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1);
    check_eq("lui_no_stall", bus_if.pc_stall, 32'd0);

    // Load in MEM, memory not ready for 3 cycles.
    do_reset();
    step(1'b1, OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    check_eq("mw1_bubble", bus_if.mem_wb_bubble, 32'd1);
    check_eq("mw1_wait",   bus_if.dmem_wait,     32'd0);
    idle(1'b0, 1'b0);
    check_eq("mw2_wait",   bus_if.dmem_wait,     32'd1);
    check_eq("mw2_mem",    bus_if.mem_addr,      32'd5);
    check_eq("mw2_wb",     bus_if.wb_addr,       32'd0);
    idle(1'b0, 1'b0);
    check_eq("mw3_bubble", bus_if.mem_wb_bubble, 32'd1);
    check_eq("mw3_mem",    bus_if.mem_addr,      32'd5);
    idle(1'b0, 1'b1);
    check_eq("mw_done_bubble", bus_if.mem_wb_bubble, 32'd0);
    check_eq("mw_done_cnt",    bus_if.stall_cnt,     32'd3);
    idle(1'b0, 1'b1);
    check_eq("mw_wb_load", bus_if.wb_addr, 32'd5);

    // Redirect together with load-use: flush wins, no PC stall.
    do_reset();
    step(1'b1, OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0, 1'b1);
    step(1'b1, OP_OP, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1);
    check_eq("rl_flush",  bus_if.if_id_flush,  32'd1);
    check_eq("rl_bubble", bus_if.id_ex_bubble, 32'd1);
    check_eq("rl_pc",     bus_if.pc_stall,     32'd0);

    // Redirect during a memory freeze is deferred until memory answers.
    do_reset();
    step(1'b1, OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0, 1'b1);
    step(1'b1, OP_OP, 5'd9, 5'd1, 5'd2, 1'b0, 1'b1);
    step(1'b1, OP_OP, 5'd10, 5'd1, 5'd2, 1'b1, 1'b0);
    check_eq("rh_pc",    bus_if.pc_stall,    32'd1);
    check_eq("rh_flush", bus_if.if_id_flush, 32'd0);
    step(1'b1, OP_OP, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1);
    check_eq("rh_flush2", bus_if.if_id_flush, 32'd1);
    check_eq("rh_ex",     bus_if.ex_addr,     32'd9);
    idle(1'b0, 1'b1);
    check_eq("rh_after_ex",  bus_if.ex_addr,  32'd0);
    check_eq("rh_after_mem", bus_if.mem_addr, 32'd9);
    check_eq("rh_after_wb",  bus_if.wb_addr,  32'd5);

    // Counter saturation over 65 540 frozen cycles.
    do_reset();
    step(1'b1, OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    @(negedge clk);
    bus_if.id_valid   = 1'b0;
    bus_if.dmem_ready = 1'b0;
    repeat (65540) @(negedge clk);
    pipe[2].v = 1'b0;
    m_wait    = 1'b1;
    m_cnt     = 65535;
    idle(1'b0, 1'b0);
    check_eq("sat_cnt", bus_if.stall_cnt, 32'hFFFF);
    check_eq("sat_mem", bus_if.mem_addr,  32'd5);
    idle(1'b0, 1'b1);

    // Randomized traffic, with a reset dropped in mid-stream.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int n = 0; n < 1500; n++) begin
        logic [6:0] op;
        case ($urandom_range(0, 9))
          0: op = OP_LOAD;
          1: op = OP_STORE;
          2: op = OP_BRANCH;
          3: op = OP_JALR;
          4: op = OP_JAL;
          5: op = OP_OPIMM;
          6: op = OP_OP;
          7: op = OP_LUI;
          8: op = OP_AUIPC;
          default: op = OP_JUNK;
        endcase
        if ($urandom_range(0, 3) == 0) op = OP_LOAD;
        step($urandom_range(0, 7) != 0, op,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)),
             $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Decode-stage hazard and in-flight destination tracker for the 5-stage RISC-V pipeline. It records the destination register of every instruction that leaves ID and supplies the stage-aligned `ex_addr`, `mem_addr` and `wb_addr` values consumed by the operand forwarding logic. It also generates every pipeline stall, flush and bubble: load-use interlock, data-memory wait freeze, and control-transfer redirect flush. A saturating stall-cycle counter is kept for performance monitoring.

## Interface
- No parameters.
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_opcode` in 7: ID instruction opcode.
- `id_rd`, `id_rs1`, `id_rs2` in 5 each: ID register fields.
- `ex_redirect` in 1: taken branch or jump resolved in EX this cycle.
- `dmem_ready` in 1: data memory completes the access presented by MEM this cycle.
- `ex_addr`, `mem_addr`, `wb_addr` out 5 each: destination of the instruction in EX, MEM and WB. The value is 0 if the slot is invalid or the instruction does not write rd.
- `pc_stall` out 1: hold the PC.
- `if_id_stall` out 1: hold the IF/ID register.
- `if_id_flush` out 1: zero IF/ID to a bubble.
- `id_ex_stall` out 1: hold the ID/EX register.
- `id_ex_bubble` out 1: load a bubble into ID/EX.
- `ex_mem_stall` out 1: hold the EX/MEM register.
- `mem_wb_bubble` out 1: load a bubble into MEM/WB.
- `dmem_wait` out 1: FSM is in WAIT (registered).
- `stall_cnt` out 16: count of stall cycles, saturating.

## Operation
- Opcode classes:
  - LOAD = 0000011, STORE = 0100011, BRANCH = 1100011, JALR = 1100111, JAL = 1101111, OP-IMM = 0010011, OP = 0110011, LUI = 0110111, AUIPC = 0010111.
  - uses_rs1: JALR, LOAD, STORE, OP-IMM, OP, BRANCH.
  - uses_rs2: STORE, OP, BRANCH.
  - writes_rd: any valid opcode except STORE and BRANCH, and only when rd ≠ 0.
  - is_mem: LOAD or STORE.
- Each of the three slots (EX, MEM, WB) holds {valid, wr, rd, is_load, is_mem}.
- Normal cycle:
  - ID decode → EX slot; EX → MEM; MEM → WB.
  - The old WB content is retired.
- Load-use hazard (`lu`) is asserted when all of the following hold:
  - EX slot is valid and is_load, with wr set.
  - id_valid is high.
  - EX rd matches rs1 with uses_rs1, or EX rd matches rs2 with uses_rs2.
- Action priority, combinational, evaluated each cycle:
  1. `mem_hold` = MEM slot valid & is_mem & ~dmem_ready.
     - Assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble.
     - EX and MEM slots hold; WB slot becomes invalid.
     - ex_redirect is ignored this cycle. EX is frozen, so it is re-presented later.
  2. `ex_redirect`:
     - Assert if_id_flush and id_ex_bubble.
     - EX slot becomes invalid; MEM and WB advance.
     - lu is ignored because the ID instruction is squashed.
  3. `lu`:
     - Assert pc_stall, if_id_stall, id_ex_bubble.
     - EX slot becomes invalid; the load advances to MEM.
  4. Otherwise, all control outputs are 0 and the slots advance normally.
- FSM, 2 states:
  - RUN → WAIT when mem_hold.
  - WAIT → RUN when dmem_ready.
  - The state drives dmem_wait only. Stall outputs are always combinational from the current inputs.
- stall_cnt increments by 1 in any cycle where pc_stall = 1, and saturates at 0xFFFF.

## Timing
- Reset (asynchronous, immediate):
  - All slots invalid; ex_addr, mem_addr and wb_addr = 0.
  - FSM = RUN; dmem_wait = 0; stall_cnt = 0.
  - Combinational outputs are evaluated against the invalid slots, so they are 0 unless ex_redirect is high.
  - Asserting reset mid-stall discards all slot contents.
- Address outputs are registered, straight from the slots. There is zero combinational path from the ID inputs to the address outputs.
- The load-use interlock is exactly 1 bubble. In the following cycle the load sits in MEM, and lu cannot re-fire for the same pair.
- A mem_hold lasting N cycles produces N stall cycles and N WB bubbles. No slot content is lost.
- A redirect flush lasts 1 cycle per ex_redirect pulse.
- Writes to x0 never appear: wr = 0, so the output address is 0. The x0 read path is guaranteed zero by the datapath, so an address match on 0 is harmless.

## Test plan
- Reset asserted mid-stream with full slots → all addresses 0, stall_cnt 0, dmem_wait 0 in the same cycle; after release, a normal OP x5 appears on ex_addr = 5 one cycle later.
- Sequence `lw x5` followed by `add x6,x5,x7` → in the cycle the add is in ID, pc_stall = if_id_stall = id_ex_bubble = 1; next cycle ex_addr = 0, mem_addr = 5; stall_cnt = 1.
- `lw x5` followed by `sw x8,0(x5)` → stall occurs (rs1 used). `lw x5` followed by `lui x5` → no stall.
- Load in MEM with dmem_ready low for 3 cycles → dmem_wait is high from the 2nd cycle; mem_wb_bubble is high for 3 cycles; mem_addr stays constant; wb_addr = 0 during the wait; stall_cnt = 3.
- ex_redirect and lu in the same cycle → if_id_flush = id_ex_bubble = 1, pc_stall = 0; ex_redirect and mem_hold together → only the freeze, and the redirect takes effect after dmem_ready.
- Force 65 540 stall cycles → stall_cnt stays at 0xFFFF.
